// File: rtl/mold_msg_sequencer_if.sv
// Byte-stream input and decoded header/message outputs of the MoldUDP64 sequencer.
// slave is the sequencer's view, master is the upstream/downstream agent's view.
interface mold_msg_sequencer_if;
  logic        inValid;
  logic [7:0]  inData;
  logic        inSof;
  logic        inEof;
  logic        hdrValid;
  logic [79:0] sessId;
  logic [63:0] seqNum;
  logic [15:0] msgCnt;
  logic        msgValid;
  logic [7:0]  msgData;
  logic        msgSof;
  logic        msgEof;
  logic        msgAbort;
  logic        truncErr;
  logic        lenErr;
  logic        endSess;
  logic        gapErr;
  logic        dupDrop;

  modport master (
    output inValid, inData, inSof, inEof,
    input  hdrValid, sessId, seqNum, msgCnt, msgValid, msgData, msgSof, msgEof,
    input  msgAbort, truncErr, lenErr, endSess, gapErr, dupDrop
  );

  modport slave (
    input  inValid, inData, inSof, inEof,
    output hdrValid, sessId, seqNum, msgCnt, msgValid, msgData, msgSof, msgEof,
    output msgAbort, truncErr, lenErr, endSess, gapErr, dupDrop
  );
endinterface

// File: rtl/mold_msg_sequencer.sv
// MoldUDP64 payload sequencer: header fields out, ITCH bodies framed; MOLD_SEQ_CHECK_EN adds seq gap/dup checks.
// All outputs registered, 1 cycle after each accepted byte; no backpressure, input gaps allowed.
module mold_msg_sequencer #(
  parameter int MAX_MSG_LEN = 50,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  mold_msg_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_LEN_LO = 3'd3;
  localparam logic [2:0] S_BODY   = 3'd4;
  localparam logic [2:0] S_SKIP   = 3'd5;
  localparam logic [2:0] S_DRAIN  = 3'd6;

  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(19);
  localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(MAX_MSG_LEN);

  logic [2:0]       state_q, state_d, nxt_state;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] msgs_left_q, msgs_left_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [151:0]     hdr_buf_q, hdr_buf_d;
  logic [79:0]      sess_id_q, sess_id_d;
  logic [63:0]      seq_num_q, seq_num_d;
  logic [15:0]      msg_cnt_q, msg_cnt_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic             msg_valid_q, msg_valid_d;
  logic [7:0]       msg_data_q, msg_data_d;
  logic             msg_sof_q, msg_sof_d;
  logic             msg_eof_q, msg_eof_d;
  logic             msg_abort_q, msg_abort_d;
  logic             trunc_err_q, trunc_err_d;
  logic             len_err_q, len_err_d;
  logic             end_sess_q, end_sess_d;
  logic             gap_err_q, gap_err_d;
  logic             dup_drop_q, dup_drop_d;

  logic [159:0]     hdr_full;
  logic [79:0]      new_sess;
  logic [63:0]      new_seq;
  logic [15:0]      new_cnt;
  logic [CNT_W-1:0] byte_inc, msgs_dec, len_full;
  logic             hdr_done, hdr_drop, hdr_gap, msg_last, msgs_done;

  always_comb begin
    // header as it stands once the byte now on the bus is appended
    hdr_full  = {hdr_buf_q, bus.inData};
    new_sess  = hdr_full[159:80];
    new_seq   = hdr_full[79:16];
    new_cnt   = hdr_full[15:0];
    byte_inc  = (byte_cnt_q == CNT_SAT) ? byte_cnt_q : byte_cnt_q + ONE;
    msgs_dec  = (msgs_left_q == '0) ? '0 : msgs_left_q - ONE;
    msgs_done = (msgs_dec == '0);
    len_full  = CNT_W'({len_hi_q, bus.inData});
    msg_last  = (byte_cnt_q == len_q - ONE);
    hdr_done  = bus.inValid && !bus.inSof && (state_q == S_HDR) && (byte_cnt_q == HDR_LAST);
  end

`ifdef MOLD_SEQ_CHECK_EN
  logic [63:0] exp_seq_q, exp_seq_d;
  logic        seq_init_q, seq_init_d;
  logic        seq_chk;

  always_comb begin
    seq_chk    = (new_cnt != 16'h0000) && (new_cnt != 16'hFFFF);
    hdr_drop   = seq_chk && seq_init_q && (new_seq < exp_seq_q);
    hdr_gap    = seq_chk && seq_init_q && (new_seq > exp_seq_q);
    exp_seq_d  = exp_seq_q;
    seq_init_d = seq_init_q;
    if (hdr_done && seq_chk && !hdr_drop) begin
      exp_seq_d  = new_seq + 64'(new_cnt);
      seq_init_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_seq_q  <= '0;
      seq_init_q <= 1'b0;
    end else begin
      exp_seq_q  <= exp_seq_d;
      seq_init_q <= seq_init_d;
    end
  end
`else
  assign hdr_drop = 1'b0;
  assign hdr_gap  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    nxt_state   = state_q;
    byte_cnt_d  = byte_cnt_q;
    msgs_left_d = msgs_left_q;
    len_d       = len_q;
    len_hi_d    = len_hi_q;
    hdr_buf_d   = hdr_buf_q;
    sess_id_d   = sess_id_q;
    seq_num_d   = seq_num_q;
    msg_cnt_d   = msg_cnt_q;
    hdr_valid_d = 1'b0;
    msg_valid_d = 1'b0;
    msg_data_d  = msg_data_q;
    msg_sof_d   = 1'b0;
    msg_eof_d   = 1'b0;
    msg_abort_d = 1'b0;
    trunc_err_d = 1'b0;
    len_err_d   = 1'b0;
    end_sess_d  = 1'b0;
    gap_err_d   = hdr_done && hdr_gap;
    dup_drop_d  = hdr_done && hdr_drop;

    if (bus.inValid) begin
      if (bus.inSof) begin
        // a restart abandons whatever datagram was still owed messages
        trunc_err_d = (state_q != S_IDLE) && (state_q != S_DRAIN);
        msg_abort_d = (state_q == S_BODY);
        hdr_buf_d   = {hdr_buf_q[143:0], bus.inData};
        byte_cnt_d  = ONE;
        if (bus.inEof) begin
          trunc_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_HDR;
        end
      end else begin
        case (state_q)
          S_HDR: begin
            hdr_buf_d  = {hdr_buf_q[143:0], bus.inData};
            byte_cnt_d = byte_inc;
            if (hdr_done) begin
              if (hdr_drop) begin
                nxt_state = S_DRAIN;
              end else begin
                hdr_valid_d = 1'b1;
                sess_id_d   = new_sess;
                seq_num_d   = new_seq;
                msg_cnt_d   = new_cnt;
                end_sess_d  = (new_cnt == 16'hFFFF);
                msgs_left_d = CNT_W'(new_cnt);
                nxt_state   = ((new_cnt == 16'h0000) || (new_cnt == 16'hFFFF)) ? S_DRAIN : S_LEN_HI;
              end
              state_d     = bus.inEof ? S_IDLE : nxt_state;
              trunc_err_d = bus.inEof && (nxt_state == S_LEN_HI);
            end else if (bus.inEof) begin
              trunc_err_d = 1'b1;
              state_d     = S_IDLE;
            end
          end
          S_LEN_HI: begin
            len_hi_d = bus.inData;
            if (bus.inEof) begin
              trunc_err_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              state_d = S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            len_d      = len_full;
            byte_cnt_d = '0;
            if (len_full == '0) begin
              msgs_left_d = msgs_dec;
              nxt_state   = msgs_done ? S_DRAIN : S_LEN_HI;
            end else if (len_full > LEN_MAX) begin
              len_err_d = 1'b1;
              nxt_state = S_SKIP;
            end else begin
              nxt_state = S_BODY;
            end
            if (bus.inEof) begin
              state_d     = S_IDLE;
              trunc_err_d = !((len_full == '0) && msgs_done);
            end else begin
              state_d = nxt_state;
            end
          end
          S_BODY, S_SKIP: begin
            byte_cnt_d = byte_inc;
            if (state_q == S_BODY) begin
              msg_valid_d = 1'b1;
              msg_data_d  = bus.inData;
              msg_sof_d   = (byte_cnt_q == '0);
              msg_eof_d   = msg_last;
            end
            if (msg_last) begin
              msgs_left_d = msgs_dec;
              nxt_state   = msgs_done ? S_DRAIN : S_LEN_HI;
            end
            // ending on the last byte of the last message is the normal case
            if (bus.inEof) begin
              state_d     = S_IDLE;
              trunc_err_d = !(msg_last && msgs_done);
              msg_abort_d = (state_q == S_BODY) && !msg_last;
            end else begin
              state_d = nxt_state;
            end
          end
          S_DRAIN: begin
            if (bus.inEof) state_d = S_IDLE;
          end
          S_IDLE: begin
            state_d = S_IDLE;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      msgs_left_q <= '0;
      len_q       <= '0;
      len_hi_q    <= '0;
      hdr_buf_q   <= '0;
      sess_id_q   <= '0;
      seq_num_q   <= '0;
      msg_cnt_q   <= '0;
      hdr_valid_q <= 1'b0;
      msg_valid_q <= 1'b0;
      msg_data_q  <= '0;
      msg_sof_q   <= 1'b0;
      msg_eof_q   <= 1'b0;
      msg_abort_q <= 1'b0;
      trunc_err_q <= 1'b0;
      len_err_q   <= 1'b0;
      end_sess_q  <= 1'b0;
      gap_err_q   <= 1'b0;
      dup_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      msgs_left_q <= msgs_left_d;
      len_q       <= len_d;
      len_hi_q    <= len_hi_d;
      hdr_buf_q   <= hdr_buf_d;
      sess_id_q   <= sess_id_d;
      seq_num_q   <= seq_num_d;
      msg_cnt_q   <= msg_cnt_d;
      hdr_valid_q <= hdr_valid_d;
      msg_valid_q <= msg_valid_d;
      msg_data_q  <= msg_data_d;
      msg_sof_q   <= msg_sof_d;
      msg_eof_q   <= msg_eof_d;
      msg_abort_q <= msg_abort_d;
      trunc_err_q <= trunc_err_d;
      len_err_q   <= len_err_d;
      end_sess_q  <= end_sess_d;
      gap_err_q   <= gap_err_d;
      dup_drop_q  <= dup_drop_d;
    end
  end

  assign bus.hdrValid = hdr_valid_q;
  assign bus.sessId   = sess_id_q;
  assign bus.seqNum   = seq_num_q;
  assign bus.msgCnt   = msg_cnt_q;
  assign bus.msgValid = msg_valid_q;
  assign bus.msgData  = msg_data_q;
  assign bus.msgSof   = msg_sof_q;
  assign bus.msgEof   = msg_eof_q;
  assign bus.msgAbort = msg_abort_q;
  assign bus.truncErr = trunc_err_q;
  assign bus.lenErr   = len_err_q;
  assign bus.endSess  = end_sess_q;
  assign bus.gapErr   = gap_err_q;
  assign bus.dupDrop  = dup_drop_q;

endmodule

// File: tb/tb_mold_msg_sequencer.sv
// Bench for mold_msg_sequencer: datagrams are built from header/message layouts and the
// expected per-byte outputs are derived from byte offsets within that layout.
module tb_mold_msg_sequencer;
  localparam int MAX_MSG_LEN = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mold_msg_sequencer_if bus();

  mold_msg_sequencer #(.MAX_MSG_LEN(MAX_MSG_LEN), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic hv, es, mv, ms, me, ma, te, le, ge, dd;
    logic [7:0] md;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    exp_t       e;
  } beat_t;

  beat_t       beats[$];
  exp_t        prev_exp;
  int          checks   = 0;
  int          failures = 0;
  bit          pend_te, pend_ma;
  logic [79:0] held_sess;
  logic [63:0] held_seq;
  logic [15:0] held_cnt;
  logic [63:0] m_exp_seq;
  bit          m_seq_init;
  int          dg_idx;

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s (dg %0d): got %0h expected %0h", tag, dg_idx, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_flags();
    return {bus.hdrValid, bus.endSess, bus.msgValid, bus.msgSof, bus.msgEof,
            bus.msgAbort, bus.truncErr, bus.lenErr, bus.gapErr, bus.dupDrop};
  endfunction

  function automatic logic [9:0] exp_flags(input exp_t e);
    return {e.hv, e.es, e.mv, e.ms, e.me, e.ma, e.te, e.le, e.ge, e.dd};
  endfunction

  // one cycle: check what the previous cycle's byte produced, then drive the next input
  task automatic step(input bit v, input beat_t bt);
    @(negedge clk);
    check_eq("flags{hv,es,mv,ms,me,ma,te,le,ge,dd}", 80'(obs_flags()), 80'(exp_flags(prev_exp)));
    if (prev_exp.mv) check_eq("msgData", 80'(bus.msgData), 80'(prev_exp.md));
    bus.inValid = v;
    bus.inData  = v ? bt.d   : 8'($urandom);
    bus.inSof   = v ? bt.sof : 1'($urandom);
    bus.inEof   = v ? bt.eof : 1'($urandom);
    prev_exp    = v ? bt.e : '0;
  endtask

  task automatic idle(input int n);
    beat_t nb;
    nb.d = '0; nb.sof = 1'b0; nb.eof = 1'b0; nb.e = '0;
    for (int i = 0; i < n; i++) step(1'b0, nb);
  endtask

  task automatic send_all(input int gap_mode);
    bit v;
    bit tog;
    tog = 1'b0;
    while (beats.size() != 0) begin
      case (gap_mode)
        0:       v = ($urandom_range(0, 3) != 0);
        1:       begin tog = !tog; v = tog; end
        default: v = 1'b1;
      endcase
      step(v, beats[0]);
      if (v) void'(beats.pop_front());
    end
  endtask

  // Build one datagram, derive expectations per byte, and queue the first n bytes.
  task automatic gen_dgram(input logic [63:0] seq, input logic [15:0] cnt, input int lens[$],
                           input int trail, input int n_cut, input bit restart);
    logic [7:0]  b[$];
    exp_t        e[$];
    bit          fwd[$];
    bit          lastb[$];
    logic [79:0] sess;
    exp_t        z;
    exp_t        r;
    logic [7:0]  d;
    beat_t       bt;
    int          completion, n, len;
    bit          chk_seq, drop, gap;

    z    = '0;
    sess = {16'($urandom), 32'($urandom), 32'($urandom)};
    for (int i = 0; i < 10; i++) b.push_back(sess[79-8*i -: 8]);
    for (int i = 0; i < 8; i++)  b.push_back(seq[63-8*i -: 8]);
    b.push_back(cnt[15:8]);
    b.push_back(cnt[7:0]);
    for (int i = 0; i < 20; i++) begin e.push_back(z); fwd.push_back(1'b0); lastb.push_back(1'b0); end

    chk_seq = (cnt != 16'h0000) && (cnt != 16'hFFFF);
    drop = 1'b0;
    gap  = 1'b0;
`ifdef MOLD_SEQ_CHECK_EN
    if (chk_seq && m_seq_init) begin
      drop = (seq < m_exp_seq);
      gap  = (seq > m_exp_seq);
    end
`endif
    e[19].hv = !drop;
    e[19].es = (cnt == 16'hFFFF);
    e[19].ge = gap;
    e[19].dd = drop;
    completion = 19;

    if (chk_seq) begin
      for (int m = 0; m < int'(cnt); m++) begin
        len = lens[m];
        b.push_back(8'(len >> 8));
        b.push_back(8'(len));
        r = z;
        r.le = !drop && (len > MAX_MSG_LEN);
        e.push_back(z);
        e.push_back(r);
        for (int k = 0; k < 2; k++) begin fwd.push_back(1'b0); lastb.push_back(1'b0); end
        if (!drop && len == 0) completion = e.size() - 1;
        for (int j = 0; j < len; j++) begin
          d = 8'($urandom);
          r = z;
          if (!drop && len <= MAX_MSG_LEN) begin
            r.mv = 1'b1; r.md = d; r.ms = (j == 0); r.me = (j == len - 1);
          end
          b.push_back(d);
          e.push_back(r);
          fwd.push_back(!drop && len <= MAX_MSG_LEN);
          lastb.push_back(j == len - 1);
          if (!drop) completion = e.size() - 1;
        end
      end
    end
    for (int t = 0; t < trail; t++) begin
      b.push_back(8'($urandom)); e.push_back(z); fwd.push_back(1'b0); lastb.push_back(1'b0);
    end

    n = (n_cut > 0 && n_cut < b.size()) ? n_cut : b.size();
    e[0].te = e[0].te | pend_te;
    e[0].ma = e[0].ma | pend_ma;
    if (!restart) begin
      if (n - 1 < completion) e[n-1].te = 1'b1;
      if (fwd[n-1] && !lastb[n-1]) e[n-1].ma = 1'b1;
      pend_te = 1'b0;
      pend_ma = 1'b0;
    end else begin
      pend_te = (n <= completion);
      pend_ma = (n < b.size()) && fwd[n];
    end

    if (n >= 20) begin
      if (!drop) begin held_sess = sess; held_seq = seq; held_cnt = cnt; end
      if (chk_seq && !drop) begin m_exp_seq = seq + 64'(cnt); m_seq_init = 1'b1; end
    end

    for (int i = 0; i < n; i++) begin
      bt.d = b[i]; bt.sof = (i == 0); bt.eof = !restart && (i == n - 1); bt.e = e[i];
      beats.push_back(bt);
    end
  endtask

  task automatic dg(input logic [63:0] seq, input logic [15:0] cnt, input int lens[$],
                    input int trail, input int n_cut, input bit restart, input int gap_mode);
    dg_idx++;
    gen_dgram(seq, cnt, lens, trail, n_cut, restart);
    send_all(gap_mode);
    idle(2);
    check_eq("sessId", bus.sessId, held_sess);
    check_eq("seqNum", 80'(bus.seqNum), 80'(held_seq));
    check_eq("msgCnt", 80'(bus.msgCnt), 80'(held_cnt));
  endtask

  function automatic int rand_len();
    case ($urandom_range(0, 9))
      0:       return 0;
      1:       return 1;
      2:       return MAX_MSG_LEN;
      3:       return MAX_MSG_LEN + 1;
      default: return int'($urandom_range(2, 60));
    endcase
  endfunction

  initial begin
    int          lq[$];
    logic [15:0] c;
    logic [63:0] s;
    int          ncut;

    bus.inValid = 1'b0; bus.inData = '0; bus.inSof = 1'b0; bus.inEof = 1'b0;
    prev_exp = '0; pend_te = 1'b0; pend_ma = 1'b0; dg_idx = 0;
    held_sess = '0; held_seq = '0; held_cnt = '0; m_exp_seq = '0; m_seq_init = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset flags", 80'(obs_flags()), 80'(0));
    check_eq("reset msgData", 80'(bus.msgData), 80'(0));
    check_eq("reset sessId", bus.sessId, 80'(0));
    check_eq("reset seqNum", 80'(bus.seqNum), 80'(0));
    check_eq("reset msgCnt", 80'(bus.msgCnt), 80'(0));

    // sequence checking: accept, in-order, gap, duplicate
    lq = {4, 0, 2};  dg(64'd100, 16'd3, lq, 1, 0, 1'b0, 2);
    lq = {3};        dg(64'd103, 16'd1, lq, 0, 0, 1'b0, 2);
    lq = {5};        dg(64'd110, 16'd1, lq, 0, 0, 1'b0, 2);
    lq = {6, 7};     dg(64'd105, 16'd2, lq, 0, 0, 1'b0, 2);
    // two messages 36 and 1, back to back then with alternate-cycle gaps
    lq = {36, 1};    dg(m_exp_seq, 16'd2, lq, 0, 0, 1'b0, 2);
    lq = {36, 1};    dg(m_exp_seq, 16'd2, lq, 0, 0, 1'b0, 1);
    // heartbeat and end of session, each with trailing bytes
    lq.delete();     dg(m_exp_seq, 16'h0000, lq, 4, 0, 1'b0, 2);
    lq.delete();     dg(m_exp_seq, 16'hFFFF, lq, 4, 0, 1'b0, 2);
    // early end mid-body of message 2, restart mid-header, then a clean datagram
    lq = {5, 36, 7}; dg(m_exp_seq, 16'd3, lq, 0, 39, 1'b0, 2);
    lq = {5};        dg(m_exp_seq, 16'd1, lq, 0, 8, 1'b1, 2);
    lq = {3, 4};     dg(m_exp_seq, 16'd2, lq, 2, 0, 1'b0, 2);
    // oversize length skipped, following message intact; size boundaries
    lq = {60, 20};   dg(m_exp_seq, 16'd2, lq, 0, 0, 1'b0, 2);
    lq = {50, 51, 0, 1}; dg(m_exp_seq, 16'd4, lq, 1, 0, 1'b0, 2);
    // single-byte datagram
    lq = {3};        dg(m_exp_seq, 16'd1, lq, 0, 1, 1'b0, 2);

    for (int k = 0; k < 40; k++) begin
      int r;
      r = int'($urandom_range(0, 15));
      lq.delete();
      if (r == 0)      c = 16'h0000;
      else if (r == 1) c = 16'hFFFF;
      else             c = 16'($urandom_range(1, 4));
      if (c != 16'h0000 && c != 16'hFFFF)
        for (int m = 0; m < int'(c); m++) lq.push_back(rand_len());
      s = m_exp_seq + 64'($urandom_range(0, 4)) - 64'd2;
      ncut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0;
      dg(s, c, lq, int'($urandom_range(0, 3)), ncut,
         (ncut != 0) && ($urandom_range(0, 1) == 1), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
